// File: rtl/req_mon_pkg.sv
// req_mon_pkg: shared types and defaults for the request protocol monitor.
//   rule_e   - indexes one channel's violation vector (one bit per rule)
//   gap_st_e - high-priority gap timer state
//   DEF_*    - default parameter values for the top and channel modules
package req_mon_pkg;

  typedef enum logic [1:0] {
    RULE_RST   = 2'd0,
    RULE_VALID = 2'd1,
    RULE_BURST = 2'd2,
    RULE_HP    = 2'd3
  } rule_e;

  localparam int NUM_RULES = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } gap_st_e;

  localparam int DEF_NCH       = 4;
  localparam int DEF_PRIO_W    = 2;
  localparam int DEF_MAX_BURST = 3;
  localparam int DEF_HP_GAP    = 5;
  localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/req_mon_chan.sv
// req_mon_chan: rule checker for one request channel.
//   clk, reset      - monitor clock, synchronous active-high reset
//   dut_rst_n       - monitored-domain reset, sampled as data
//   req, valid      - channel request and data-valid qualifier
//   prio            - channel priority (all-ones = high priority)
//   viol            - registered one-cycle violation pulses, indexed by rule_e
// Optional: define REQ_MON_SVA_EN to add one concurrent assertion per rule.
module req_mon_chan
  import req_mon_pkg::*;
#(
  parameter int PRIO_W    = DEF_PRIO_W,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int HP_GAP    = DEF_HP_GAP,
  parameter int CH_ID     = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dut_rst_n,
  input  logic                 req,
  input  logic                 valid,
  input  logic [PRIO_W-1:0]    prio,
  output logic [NUM_RULES-1:0] viol
);

  localparam int RUN_W = $clog2(MAX_BURST + 1);
  localparam int GAP_W = $clog2(HP_GAP + 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_BURST);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(HP_GAP - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  logic             hp;
  logic [RUN_W-1:0] run_cnt;
  logic [GAP_W-1:0] gap_tmr;
  gap_st_e          gap_st;

  assign hp = req & (&prio);

  always_ff @(posedge clk) begin
    if (reset) begin
      viol    <= '0;
      run_cnt <= '0;
      gap_tmr <= '0;
      gap_st  <= IDLE;
    end else begin
      // Only the reset rule survives while the monitored domain is in reset.
      viol[RULE_RST]   <= req & ~dut_rst_n;
      viol[RULE_VALID] <= dut_rst_n & req & ~valid;
      viol[RULE_BURST] <= dut_rst_n & req & (run_cnt == RUN_MAX);
      viol[RULE_HP]    <= dut_rst_n & hp & (gap_st == HOLD);

      // Run counter saturates so every req beyond the limit keeps flagging.
      if (!dut_rst_n || !req)
        run_cnt <= '0;
      else if (run_cnt != RUN_MAX)
        run_cnt <= run_cnt + 1'b1;

      // A high-priority req seen while holding flags but does not restart the gap.
      if (!dut_rst_n) begin
        gap_st  <= IDLE;
        gap_tmr <= '0;
      end else begin
        case (gap_st)
          IDLE: if (hp && HP_GAP > 1) begin
            gap_st  <= HOLD;
            gap_tmr <= GAP_LOAD;
          end
          HOLD: begin
            gap_tmr <= gap_tmr - 1'b1;
            if (gap_tmr == GAP_ONE) gap_st <= IDLE;
          end
          default: gap_st <= IDLE;
        endcase
      end
    end
  end

`ifdef REQ_MON_SVA_EN
  a_rst: assert property (@(posedge clk) disable iff (reset)
    !(req && !dut_rst_n))
    else $error("ch%0d RULE_RST: req while dut_rst_n low", CH_ID);
  a_valid: assert property (@(posedge clk) disable iff (reset || !dut_rst_n)
    req |-> valid)
    else $error("ch%0d RULE_VALID: req without valid", CH_ID);
  a_burst: assert property (@(posedge clk) disable iff (reset || !dut_rst_n)
    !(req && run_cnt == RUN_MAX))
    else $error("ch%0d RULE_BURST: req run exceeds %0d", CH_ID, MAX_BURST);
  a_hp: assert property (@(posedge clk) disable iff (reset || !dut_rst_n)
    !(hp && gap_st == HOLD))
    else $error("ch%0d RULE_HP: high-priority req inside %0d-cycle gap", CH_ID, HP_GAP);
`endif

endmodule

// File: rtl/req_protocol_monitor.sv
// req_protocol_monitor: per-channel request protocol checker with a sticky
// error flag and a saturating violation-cycle counter.
//   clk, reset                 - monitor clock, synchronous active-high reset
//   dut_rst_n                  - monitored-domain reset (data, active-low)
//   req, valid [NCH]           - per-channel request / data-valid
//   prio [NCH*PRIO_W]          - per-channel priority, channel i at [i*PRIO_W +: PRIO_W]
//   clr                        - synchronous clear of err_any / err_cnt
//   fire [NCH]                 - combinational req & valid
//   viol_rst/valid/burst/hp    - registered one-cycle violation pulses
//   err_any, err_cnt           - sticky error, saturating violation-cycle count
// Optional: define REQ_MON_SVA_EN to add per-channel rule assertions.
module req_protocol_monitor
  import req_mon_pkg::*;
#(
  parameter int NCH       = DEF_NCH,
  parameter int PRIO_W    = DEF_PRIO_W,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int HP_GAP    = DEF_HP_GAP,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dut_rst_n,
  input  logic [NCH-1:0]        req,
  input  logic [NCH-1:0]        valid,
  input  logic [NCH*PRIO_W-1:0] prio,
  input  logic                  clr,
  output logic [NCH-1:0]        fire,
  output logic [NCH-1:0]        viol_rst,
  output logic [NCH-1:0]        viol_valid,
  output logic [NCH-1:0]        viol_burst,
  output logic [NCH-1:0]        viol_hp,
  output logic                  err_any,
  output logic [CNT_W-1:0]      err_cnt
);

  logic [NCH-1:0][NUM_RULES-1:0] chan_viol;
  logic                          viol_cyc;

  assign fire = req & valid;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    req_mon_chan #(
      .PRIO_W    (PRIO_W),
      .MAX_BURST (MAX_BURST),
      .HP_GAP    (HP_GAP),
      .CH_ID     (g)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .dut_rst_n (dut_rst_n),
      .req       (req[g]),
      .valid     (valid[g]),
      .prio      (prio[g*PRIO_W +: PRIO_W]),
      .viol      (chan_viol[g])
    );
    assign viol_rst[g]   = chan_viol[g][RULE_RST];
    assign viol_valid[g] = chan_viol[g][RULE_VALID];
    assign viol_burst[g] = chan_viol[g][RULE_BURST];
    assign viol_hp[g]    = chan_viol[g][RULE_HP];
  end

  // A violation cycle is one where any registered pulse is visible, so the
  // counter trails the pulses by one edge and many bits count once.
  assign viol_cyc = |{viol_rst, viol_valid, viol_burst, viol_hp};

  always_ff @(posedge clk) begin
    if (reset) begin
      err_any <= 1'b0;
      err_cnt <= '0;
    end else if (clr) begin
      // Clearing in a violation cycle leaves that cycle counted.
      err_any <= viol_cyc;
      err_cnt <= CNT_W'(viol_cyc);
    end else if (viol_cyc) begin
      err_any <= 1'b1;
      if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
